// File: rtl/tc_dbuf_drain.sv
// Drain engine for the tensor-core D-tile buffer: reads each output row through the
// buffer's row port and streams it to memory as DW_MEM-bit write beats.
module tc_dbuf_drain #(
    parameter int unsigned M       = 16,
    parameter int unsigned N       = 16,
    parameter int unsigned DW_DATA = 32,
    parameter int unsigned DW_MEM  = 512,
    parameter int unsigned DW_COL  = 4,
    parameter int unsigned DW_ADDR = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [DW_ADDR-1:0]     base_addr,
    output logic                   busy,
    output logic                   done,
    output logic [DW_COL-1:0]      row_out,
    input  logic [N*DW_DATA-1:0]   D_row_in,
    output logic                   mem_wvalid,
    input  logic                   mem_wready,
    output logic [DW_ADDR-1:0]     mem_waddr,
    output logic [DW_MEM-1:0]      mem_wdata,
    output logic                   mem_wlast
);

    localparam int unsigned ROW_W          = N * DW_DATA;
    localparam int unsigned BEATS          = ROW_W / DW_MEM;
    localparam int unsigned BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned BYTES_PER_BEAT = DW_MEM / 8;

    localparam logic [DW_COL-1:0] LAST_ROW  = DW_COL'(M - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [DW_COL-1:0]   row_q, row_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ROW_W-1:0]    row_reg_q, row_reg_d;
    logic [DW_ADDR-1:0]  addr_q, addr_d;
    logic [DW_MEM-1:0]   wdata_q, wdata_d;
    logic                wlast_q, wlast_d;
    logic                wvalid_q;
    logic                busy_q;
    logic                done_q;

    // State register plus registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            beat_q    <= '0;
            row_reg_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
            wvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            beat_q    <= beat_d;
            row_reg_q <= row_reg_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wlast_q   <= wlast_d;
            wvalid_q  <= (state_d == S_SEND);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    // Next-state logic. row_reg shifts down one beat per accepted beat so the
    // next beat's data always sits in the low DW_MEM bits.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        beat_d    = beat_q;
        row_reg_d = row_reg_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wlast_d   = wlast_q;

        case (state_q)
            S_IDLE: begin
                row_d  = '0;
                beat_d = '0;
                if (start) begin
                    addr_d  = base_addr;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                row_reg_d = D_row_in;
                wdata_d   = D_row_in[DW_MEM-1:0];
                beat_d    = '0;
                wlast_d   = (row_q == LAST_ROW) && (LAST_BEAT == '0);
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (mem_wready) begin
                    addr_d = addr_q + DW_ADDR'(BYTES_PER_BEAT);
                    if (beat_q != LAST_BEAT) begin
                        beat_d    = beat_q + 1'b1;
                        row_reg_d = row_reg_q >> DW_MEM;
                        wdata_d   = row_reg_d[DW_MEM-1:0];
                        wlast_d   = (row_q == LAST_ROW) && (beat_d == LAST_BEAT);
                    end else begin
                        wlast_d = 1'b0;
                        if (row_q != LAST_ROW) begin
                            row_d   = row_q + 1'b1;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                row_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign row_out    = row_q;
    assign mem_wvalid = wvalid_q;
    assign mem_waddr  = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wlast  = wlast_q;

endmodule

// File: tb/tb_tc_dbuf_drain.sv
// Directed bench for tc_dbuf_drain: a single-beat instance (defaults) and a
// two-beat instance (N=32), both checked against a cycle model of the drain job.
module tb_tc_dbuf_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic        sel;
    logic        wready;
    logic [31:0] base_addr;

    logic         busy_a, done_a, wvalid_a, wlast_a;
    logic [3:0]   row_a;
    logic [31:0]  addr_a;
    logic [511:0] wdata_a;
    logic [511:0] drow_a;

    logic          busy_b, done_b, wvalid_b, wlast_b;
    logic [3:0]    row_b;
    logic [31:0]   addr_b;
    logic [511:0]  wdata_b;
    logic [1023:0] drow_b;

    logic         o_busy, o_done, o_wvalid, o_wlast;
    logic [3:0]   o_row;
    logic [31:0]  o_waddr;
    logic [511:0] o_wdata;

    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    tc_dbuf_drain dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start & ~sel),
        .base_addr (base_addr),
        .busy      (busy_a),
        .done      (done_a),
        .row_out   (row_a),
        .D_row_in  (drow_a),
        .mem_wvalid(wvalid_a),
        .mem_wready(wready),
        .mem_waddr (addr_a),
        .mem_wdata (wdata_a),
        .mem_wlast (wlast_a)
    );

    tc_dbuf_drain #(.N(32)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start & sel),
        .base_addr (base_addr),
        .busy      (busy_b),
        .done      (done_b),
        .row_out   (row_b),
        .D_row_in  (drow_b),
        .mem_wvalid(wvalid_b),
        .mem_wready(wready),
        .mem_waddr (addr_b),
        .mem_wdata (wdata_b),
        .mem_wlast (wlast_b)
    );

    // Buffer contents: element j of row r holds r*(elements per row)+j.
    function automatic logic [511:0] row_a_f(input logic [3:0] r);
        logic [511:0] v;
        for (int j = 0; j < 16; j++) v[j*32 +: 32] = 32'(r) * 32'd16 + 32'(j);
        return v;
    endfunction

    function automatic logic [1023:0] row_b_f(input logic [3:0] r);
        logic [1023:0] v;
        for (int j = 0; j < 32; j++) v[j*32 +: 32] = 32'(r) * 32'd32 + 32'(j);
        return v;
    endfunction

    function automatic logic [511:0] exp_beat(input int r, input int b, input int ne);
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = 32'(r * ne + b * 16 + j);
        return d;
    endfunction

    always_comb drow_a = row_a_f(row_a);
    always_comb drow_b = row_b_f(row_b);

    assign o_busy   = sel ? busy_b   : busy_a;
    assign o_done   = sel ? done_b   : done_a;
    assign o_wvalid = sel ? wvalid_b : wvalid_a;
    assign o_wlast  = sel ? wlast_b  : wlast_a;
    assign o_row    = sel ? row_b    : row_a;
    assign o_waddr  = sel ? addr_b   : addr_a;
    assign o_wdata  = sel ? wdata_b  : wdata_a;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs();
        chk("busy0",   512'(o_busy),   512'(0));
        chk("done0",   512'(o_done),   512'(0));
        chk("wvalid0", 512'(o_wvalid), 512'(0));
        chk("wlast0",  512'(o_wlast),  512'(0));
        chk("row0",    512'(o_row),    512'(0));
        chk("waddr0",  512'(o_waddr),  512'(0));
        chk("wdata0",  o_wdata,        512'(0));
    endtask

    // mode 0: ready always high; 1: 3-cycle stall on beat 5 plus random ready;
    // 2: ready high with start pulses in SEND of row 7 and in DONE.
    // abort_row >= 0 asserts reset during SEND of that row.
    task automatic run_job(input logic use_b, input logic [31:0] base, input int mode,
                           input int abort_row);
        int beats, m, r, b, stalls, stall5, done_cyc, ndone, nbeats, idle_n;
        beats = use_b ? 2 : 1;
        m = 0; r = 0; b = 0; stalls = 0; stall5 = 0;
        done_cyc = -1; ndone = 0; nbeats = 0; idle_n = 0;
        @(negedge clk);
        sel = use_b; base_addr = base; start = 1'b1; wready = 1'b1;
        for (int cyc = 1; cyc <= 400 && idle_n < 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            chk("busy",   512'(o_busy),   512'(m != 3));
            chk("done",   512'(o_done),   512'(m == 2));
            chk("wvalid", 512'(o_wvalid), 512'(m == 1));
            chk("wlast",  512'(o_wlast),  512'(m == 1 && r == 15 && b == beats - 1));
            chk("row_out", 512'(o_row),   512'(r));
            if (m == 1) begin
                chk("waddr", 512'(o_waddr), 512'(32'(base + 32'((r * beats + b) * 64))));
                chk("wdata", o_wdata, exp_beat(r, b, beats * 16));
            end
            if (o_done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
            if (m == 1 && r == abort_row) begin
                reset = 1'b1;
                @(negedge clk);
                chk_zero_outputs();
                reset = 1'b0;
                return;
            end
            wready = 1'b1;
            if (mode == 1 && m == 1) begin
                if (r * beats + b == 5 && stall5 < 3) begin
                    wready = 1'b0;
                    stall5++;
                end else begin
                    wready = 1'($urandom_range(0, 1));
                end
            end
            if (mode == 2 && ((m == 1 && r == 7) || m == 2)) start = 1'b1;
            if (o_wvalid === 1'b1 && wready) nbeats++;
            case (m)
                0: begin m = 1; b = 0; end
                1: begin
                    if (wready) begin
                        if (b < beats - 1) b++;
                        else if (r < 15) begin r++; m = 0; end
                        else m = 2;
                    end else begin
                        stalls++;
                    end
                end
                2: begin m = 3; r = 0; end
                default: idle_n++;
            endcase
        end
        start = 1'b0;
        chk("done_cycle",  512'(done_cyc), 512'(16 * (beats + 1) + 1 + stalls));
        chk("done_pulses", 512'(ndone),    512'(1));
        chk("beat_count",  512'(nbeats),   512'(16 * beats));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sel = 1'b0; wready = 1'b0; base_addr = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs();
        sel = 1'b1;
        #1;
        chk_zero_outputs();
        sel = 1'b0;
        reset = 1'b0;

        phase = "basic";      run_job(1'b0, 32'h0000_1000, 0, -1);
        phase = "backpress";  run_job(1'b0, 32'h0000_2000, 1, -1);
        phase = "multibeat";  run_job(1'b1, 32'h0000_0000, 0, -1);
        phase = "mb_backp";   run_job(1'b1, 32'h0000_0080, 1, -1);
        phase = "start_ign";  run_job(1'b0, 32'h0000_1000, 2, -1);
        phase = "abort";      run_job(1'b0, 32'h0000_1000, 0, 4);
        phase = "restart";    run_job(1'b0, 32'h0000_1000, 0, -1);
        phase = "wrap";       run_job(1'b0, 32'hFFFF_FFC0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
